// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch sequencer.
// Issues one word fetch at a time, hands the fetched instruction to issue
// under downstream back-pressure, computes the next PC from JAL/branch
// immediates, stalls on JALR until a redirect, and discards in-flight data
// on a flush.
// Optional feature: define BHT_EN to add a 16-entry table of 2-bit
// saturating branch predictors; without it every branch is predicted not taken.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; issue a fetch of pc next
// WAIT  | fetch of MC_addr outstanding, deliver on MC_done
// HOLD  | instruction latched, waiting for back-pressure to clear
// DROP  | fetch outstanding after a flush; its data will be discarded
// JWAIT | JALR delivered, no fetching until a redirect arrives
module ifetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_ins,
    input  logic        ROB_full,
    input  logic        RS_full,
    input  logic        LSB_full,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        IF_jump_flag,
    output logic [31:0] IF_jump_pc,
    input  logic        ROB_clear,
    input  logic [31:0] ROB_newpc,
    input  logic        ROB_br_sgn,
    input  logic [31:0] ROB_br_pc,
    input  logic        ROB_br_taken
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3,
        S_JWAIT = 3'd4
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mc_req_q, mc_req_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic        if_ins_sgn_q, if_ins_sgn_d;
    logic [31:0] if_ins_q, if_ins_d;
    logic        if_jump_flag_q, if_jump_flag_d;
    logic [31:0] if_jump_pc_q, if_jump_pc_d;

    logic        back_pressure;
    logic        pred_taken;
    logic        deliver;
    logic [31:0] del_ins;
    logic [6:0]  opcode;
    logic        is_jal, is_jalr, is_branch, is_auipc;
    logic [31:0] j_imm, b_imm;
    logic [31:0] pc_plus4, pc_jal, pc_br;
    logic [31:0] next_pc, jump_pc_val;
    logic        jump_flag_val;

    assign back_pressure = ROB_full | RS_full | LSB_full;

`ifdef BHT_EN
    logic [1:0] bht_q [16];
    logic [1:0] bht_d [16];
    logic [3:0] upd_idx;
    logic       unused_br_pc;

    assign upd_idx      = ROB_br_pc[5:2];
    assign unused_br_pc = ^{ROB_br_pc[31:6], ROB_br_pc[1:0]};
    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign pred_taken   = bht_q[pc_q[5:2]][1];

    // Saturating counter update for the committed branch.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (ROB_br_sgn) begin
            if (ROB_br_taken && bht_q[upd_idx] != 2'b11) begin
                bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
            end else if (!ROB_br_taken && bht_q[upd_idx] != 2'b00) begin
                bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
            end
        end
    end

    // Predictor table storage; weakly not-taken after reset, frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy) begin
            for (int i = 0; i < 16; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end
`else
    logic unused_br;

    assign unused_br  = ^{ROB_br_sgn, ROB_br_pc, ROB_br_taken};
    assign pred_taken = 1'b0;
`endif

    // Decode the instruction being delivered and derive next PC and companion PC.
    always_comb begin
        del_ins   = (state_q == S_HOLD) ? if_ins_q : MC_ins;
        opcode    = del_ins[6:0];
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_branch = (opcode == OP_BRANCH);
        is_auipc  = (opcode == OP_AUIPC);
        j_imm     = {{11{del_ins[31]}}, del_ins[31], del_ins[19:12], del_ins[20],
                     del_ins[30:21], 1'b0};
        b_imm     = {{19{del_ins[31]}}, del_ins[31], del_ins[7], del_ins[30:25],
                     del_ins[11:8], 1'b0};
        pc_plus4  = pc_q + 32'd4;
        pc_jal    = pc_q + j_imm;
        pc_br     = pc_q + b_imm;

        jump_flag_val = is_branch & pred_taken;

        next_pc = pc_plus4;
        if (is_jal) begin
            next_pc = pc_jal;
        end else if (is_jalr) begin
            next_pc = pc_q;
        end else if (jump_flag_val) begin
            next_pc = pc_br;
        end

        // Branches carry the address to recover to if the prediction is wrong.
        jump_pc_val = pc_plus4;
        if (is_auipc) begin
            jump_pc_val = pc_q;
        end else if (is_branch) begin
            jump_pc_val = pred_taken ? pc_plus4 : pc_br;
        end
    end

    // Next-state logic; a flush overrides every other event.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        mc_req_d       = mc_req_q;
        mc_addr_d      = mc_addr_q;
        if_ins_sgn_d   = 1'b0;
        if_ins_d       = if_ins_q;
        if_jump_flag_d = if_jump_flag_q;
        if_jump_pc_d   = if_jump_pc_q;
        deliver        = 1'b0;

        if (ROB_clear) begin
            pc_d = ROB_newpc;
            case (state_q)
                S_WAIT: begin
                    // Without a completion the request is still in flight and must be drained.
                    if (MC_done) begin
                        state_d  = S_IDLE;
                        mc_req_d = 1'b0;
                    end else begin
                        state_d  = S_DROP;
                    end
                end
                S_DROP: begin
                    if (MC_done) begin
                        state_d  = S_IDLE;
                        mc_req_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    mc_req_d = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    mc_req_d  = 1'b1;
                    mc_addr_d = pc_q;
                    state_d   = S_WAIT;
                end
                S_WAIT: begin
                    if (MC_done) begin
                        if_ins_d = MC_ins;
                        if (back_pressure) begin
                            state_d  = S_HOLD;
                            mc_req_d = 1'b0;
                        end else begin
                            deliver  = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!back_pressure) begin
                        deliver = 1'b1;
                    end
                end
                S_DROP: begin
                    if (MC_done) begin
                        state_d  = S_IDLE;
                        mc_req_d = 1'b0;
                    end
                end
                S_JWAIT: begin
                    state_d = S_JWAIT;
                end
                default: begin
                    state_d  = S_IDLE;
                    mc_req_d = 1'b0;
                end
            endcase

            // Delivery launches the next fetch on the same edge, except after JALR.
            if (deliver) begin
                if_ins_sgn_d   = 1'b1;
                if_jump_flag_d = jump_flag_val;
                if_jump_pc_d   = jump_pc_val;
                pc_d           = next_pc;
                if (is_jalr) begin
                    state_d  = S_JWAIT;
                    mc_req_d = 1'b0;
                end else begin
                    state_d   = S_WAIT;
                    mc_req_d  = 1'b1;
                    mc_addr_d = next_pc;
                end
            end
        end
    end

    // State and output registers; everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            pc_q           <= 32'd0;
            mc_req_q       <= 1'b0;
            mc_addr_q      <= 32'd0;
            if_ins_sgn_q   <= 1'b0;
            if_ins_q       <= 32'd0;
            if_jump_flag_q <= 1'b0;
            if_jump_pc_q   <= 32'd0;
        end else if (rdy) begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            mc_req_q       <= mc_req_d;
            mc_addr_q      <= mc_addr_d;
            if_ins_sgn_q   <= if_ins_sgn_d;
            if_ins_q       <= if_ins_d;
            if_jump_flag_q <= if_jump_flag_d;
            if_jump_pc_q   <= if_jump_pc_d;
        end
    end

    assign MC_req       = mc_req_q;
    assign MC_addr      = mc_addr_q;
    // A pulse pending across a freeze is shown once, in the first enabled cycle.
    assign IF_ins_sgn   = if_ins_sgn_q & rdy;
    assign IF_ins       = if_ins_q;
    assign IF_jump_flag = if_jump_flag_q;
    assign IF_jump_pc   = if_jump_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a per-cycle vector table plus a few
// hand-written sequences for flush, freeze, reset and predictor behaviour.
module tb_ifetch_unit;

    localparam logic [31:0] I_ADDI  = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] I_ADDI2 = 32'h00200113; // addi x2,x0,2
    localparam logic [31:0] I_JAL16 = 32'h010000EF; // jal x1,+16
    localparam logic [31:0] I_JALM8 = 32'hFF9FF06F; // jal x0,-8
    localparam logic [31:0] I_JALM4 = 32'hFFDFF06F; // jal x0,-4
    localparam logic [31:0] I_JALR  = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] I_BEQ8  = 32'h00000463; // beq x0,x0,+8
    localparam logic [31:0] I_AUIPC = 32'h00001097; // auipc x1,1
    localparam logic [31:0] I_JUNK  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_ins;
    logic        ROB_full, RS_full, LSB_full;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        IF_jump_flag;
    logic [31:0] IF_jump_pc;
    logic        ROB_clear;
    logic [31:0] ROB_newpc;
    logic        ROB_br_sgn;
    logic [31:0] ROB_br_pc;
    logic        ROB_br_taken;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .MC_req       (MC_req),
        .MC_addr      (MC_addr),
        .MC_done      (MC_done),
        .MC_ins       (MC_ins),
        .ROB_full     (ROB_full),
        .RS_full      (RS_full),
        .LSB_full     (LSB_full),
        .IF_ins_sgn   (IF_ins_sgn),
        .IF_ins       (IF_ins),
        .IF_jump_flag (IF_jump_flag),
        .IF_jump_pc   (IF_jump_pc),
        .ROB_clear    (ROB_clear),
        .ROB_newpc    (ROB_newpc),
        .ROB_br_sgn   (ROB_br_sgn),
        .ROB_br_pc    (ROB_br_pc),
        .ROB_br_taken (ROB_br_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        done;
        logic [31:0] ins;
        logic [2:0]  full;   // {ROB, RS, LSB}
        logic        clr;
        logic [31:0] newpc;
        logic        br;
        logic [31:0] br_pc;
        logic        br_tk;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sgn;
        logic        chk_if;
        logic [31:0] e_ins;
        logic        e_jf;
        logic [31:0] e_jpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic done, input logic [31:0] ins,
                                input logic [2:0] full, input logic clr,
                                input logic [31:0] newpc, input logic e_req,
                                input logic [31:0] e_addr, input logic e_sgn,
                                input logic chk_if = 1'b0, input logic [31:0] e_ins = 32'd0,
                                input logic e_jf = 1'b0, input logic [31:0] e_jpc = 32'd0);
        vec_t v;
        v.rdy    = 1'b1;
        v.done   = done;
        v.ins    = ins;
        v.full   = full;
        v.clr    = clr;
        v.newpc  = newpc;
        v.br     = 1'b0;
        v.br_pc  = 32'd0;
        v.br_tk  = 1'b0;
        v.e_req  = e_req;
        v.e_addr = e_addr;
        v.e_sgn  = e_sgn;
        v.chk_if = chk_if;
        v.e_ins  = e_ins;
        v.e_jf   = e_jf;
        v.e_jpc  = e_jpc;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        rdy          = v.rdy;
        MC_done      = v.done;
        MC_ins       = v.ins;
        ROB_full     = v.full[2];
        RS_full      = v.full[1];
        LSB_full     = v.full[0];
        ROB_clear    = v.clr;
        ROB_newpc    = v.newpc;
        ROB_br_sgn   = v.br;
        ROB_br_pc    = v.br_pc;
        ROB_br_taken = v.br_tk;
        @(posedge clk);
        #1;
        chk("MC_req", row, 32'(MC_req), 32'(v.e_req));
        chk("MC_addr", row, MC_addr, v.e_addr);
        chk("IF_ins_sgn", row, 32'(IF_ins_sgn), 32'(v.e_sgn));
        if (v.chk_if) begin
            chk("IF_ins", row, IF_ins, v.e_ins);
            chk("IF_jump_flag", row, 32'(IF_jump_flag), 32'(v.e_jf));
            chk("IF_jump_pc", row, IF_jump_pc, v.e_jpc);
        end
    endtask

    task automatic check_reset_outputs(input int row);
        chk("rst MC_req", row, 32'(MC_req), 32'd0);
        chk("rst MC_addr", row, MC_addr, 32'd0);
        chk("rst IF_ins_sgn", row, 32'(IF_ins_sgn), 32'd0);
        chk("rst IF_ins", row, IF_ins, 32'd0);
        chk("rst IF_jump_flag", row, 32'(IF_jump_flag), 32'd0);
        chk("rst IF_jump_pc", row, IF_jump_pc, 32'd0);
    endtask

    initial begin
        vec_t v;

        // Main cycle-by-cycle table, starting from IDLE with pc=0.
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h0, 0));                               // 0  fetch 0
        tbl.push_back(mk(1, I_ADDI, 3'b000, 0, 0, 1, 32'h4, 1, 1, I_ADDI, 0, 32'h4));      // 1  deliver ADDI
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h4, 0));                               // 2
        tbl.push_back(mk(1, I_ADDI2, 3'b010, 0, 0, 0, 32'h4, 0));                         // 3  RS_full -> HOLD
        tbl.push_back(mk(0, I_JUNK, 3'b010, 0, 0, 0, 32'h4, 0, 1, I_ADDI2, 0, 32'h4));     // 4  held
        tbl.push_back(mk(0, I_JUNK, 3'b010, 0, 0, 0, 32'h4, 0, 1, I_ADDI2, 0, 32'h4));     // 5  held
        tbl.push_back(mk(0, I_JUNK, 3'b000, 0, 0, 1, 32'h8, 1, 1, I_ADDI2, 0, 32'h8));     // 6  released
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h8, 0));                               // 7
        tbl.push_back(mk(1, I_JAL16, 3'b000, 0, 0, 1, 32'h18, 1, 1, I_JAL16, 0, 32'hC));   // 8  JAL +16 at 8
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h18, 0));                              // 9
        tbl.push_back(mk(1, I_AUIPC, 3'b000, 0, 0, 1, 32'h1C, 1, 1, I_AUIPC, 0, 32'h18));  // 10 AUIPC
        tbl.push_back(mk(1, I_BEQ8, 3'b000, 0, 0, 1, 32'h20, 1, 1, I_BEQ8, 0, 32'h24));    // 11 BEQ not taken
        tbl.push_back(mk(0, 0, 3'b000, 1, 32'h40, 1, 32'h20, 0));                         // 12 flush in WAIT
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h20, 0));                              // 13 DROP
        tbl.push_back(mk(1, I_ADDI, 3'b000, 0, 0, 0, 32'h20, 0));                         // 14 data dropped
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h40, 0));                              // 15 refetch 0x40
        tbl.push_back(mk(1, I_ADDI, 3'b000, 1, 32'h20, 0, 32'h40, 0));                    // 16 flush + done
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h20, 0));                              // 17
        tbl.push_back(mk(1, I_JALR, 3'b000, 0, 0, 0, 32'h20, 1, 1, I_JALR, 0, 32'h24));    // 18 JALR
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h20, 0));                              // 19 JWAIT
        tbl.push_back(mk(1, I_ADDI, 3'b000, 0, 0, 0, 32'h20, 0));                         // 20 stray done ignored
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h20, 0));                              // 21
        tbl.push_back(mk(0, 0, 3'b000, 1, 32'h100, 0, 32'h20, 0));                        // 22 redirect
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h100, 0));                             // 23
        tbl.push_back(mk(1, I_ADDI, 3'b000, 0, 0, 1, 32'h104, 1, 1, I_ADDI, 0, 32'h104));  // 24
        tbl.push_back(mk(1, I_ADDI, 3'b100, 0, 0, 0, 32'h104, 0));                        // 25 ROB_full -> HOLD
        tbl.push_back(mk(0, 0, 3'b100, 1, 32'h0, 0, 32'h104, 0));                         // 26 flush in HOLD
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h0, 0));                               // 27
        tbl.push_back(mk(1, I_JALM8, 3'b000, 0, 0, 1, 32'hFFFFFFF8, 1, 1, I_JALM8, 0, 32'h4)); // 28 wrap back
        tbl.push_back(mk(1, I_ADDI, 3'b000, 0, 0, 1, 32'hFFFFFFFC, 1, 1, I_ADDI, 0, 32'hFFFFFFFC)); // 29
        tbl.push_back(mk(1, I_ADDI, 3'b000, 0, 0, 1, 32'h0, 1, 1, I_ADDI, 0, 32'h0));      // 30 wrap fwd
        tbl.push_back(mk(1, I_ADDI2, 3'b001, 0, 0, 0, 32'h0, 0));                         // 31 LSB_full
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h4, 1, 1, I_ADDI2, 0, 32'h4));          // 32
        tbl.push_back(mk(0, 0, 3'b000, 0, 0, 1, 32'h4, 0));                               // 33

        rst = 1'b0; rdy = 1'b1; MC_done = 1'b0; MC_ins = 32'd0;
        ROB_full = 1'b0; RS_full = 1'b0; LSB_full = 1'b0;
        ROB_clear = 1'b0; ROB_newpc = 32'd0;
        ROB_br_sgn = 1'b0; ROB_br_pc = 32'd0; ROB_br_taken = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(90);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Second flush while draining only moves the target.
        apply(mk(0, 0, 3'b000, 1, 32'h80, 1, 32'h4, 0), 100);
        apply(mk(0, 0, 3'b000, 1, 32'h90, 1, 32'h4, 0), 101);
        apply(mk(1, I_ADDI, 3'b000, 0, 0, 0, 32'h4, 0), 102);
        apply(mk(0, 0, 3'b000, 0, 0, 1, 32'h90, 0), 103);

        // Freeze: completion while rdy is low is ignored, no pulse shown.
        apply(mk(1, I_ADDI, 3'b000, 0, 0, 1, 32'h94, 1, 1, I_ADDI, 0, 32'h94), 110);
        v = mk(0, 0, 3'b000, 0, 0, 1, 32'h94, 0); v.rdy = 1'b0;
        apply(v, 111);
        v = mk(1, I_ADDI2, 3'b000, 0, 0, 1, 32'h94, 0); v.rdy = 1'b0;
        apply(v, 112);
        apply(mk(0, 0, 3'b000, 0, 0, 1, 32'h94, 0), 113);
        apply(mk(1, I_ADDI2, 3'b000, 0, 0, 1, 32'h98, 1, 1, I_ADDI2, 0, 32'h98), 114);

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        MC_done = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs(120);
        @(posedge clk);
        #1;
        check_reset_outputs(121);
        @(negedge clk);
        rst = 1'b1;
        apply(mk(0, 0, 3'b000, 0, 0, 1, 32'h0, 0), 122);

        // Predictor training, then a branch at 0x10.
        v = mk(0, 0, 3'b000, 1, 32'h10, 1, 32'h0, 0);
        v.br = 1'b1; v.br_pc = 32'h10; v.br_tk = 1'b1;
        apply(v, 130);
        v = mk(0, 0, 3'b000, 0, 0, 1, 32'h0, 0);
        v.br = 1'b1; v.br_pc = 32'h10; v.br_tk = 1'b1;
        apply(v, 131);
        apply(mk(1, I_ADDI, 3'b000, 0, 0, 0, 32'h0, 0), 132);
        apply(mk(0, 0, 3'b000, 0, 0, 1, 32'h10, 0), 133);
`ifdef BHT_EN
        apply(mk(1, I_BEQ8, 3'b000, 0, 0, 1, 32'h18, 1, 1, I_BEQ8, 1, 32'h14), 134);
        // Update and lookup of the same entry in one cycle sees the old counter.
        v = mk(1, I_BEQ8, 3'b000, 0, 0, 1, 32'h1C, 1, 1, I_BEQ8, 0, 32'h20);
        v.br = 1'b1; v.br_pc = 32'h18; v.br_tk = 1'b1;
        apply(v, 135);
        apply(mk(1, I_JALM4, 3'b000, 0, 0, 1, 32'h18, 1, 1, I_JALM4, 0, 32'h20), 136);
        apply(mk(1, I_BEQ8, 3'b000, 0, 0, 1, 32'h20, 1, 1, I_BEQ8, 1, 32'h1C), 137);
`else
        apply(mk(1, I_BEQ8, 3'b000, 0, 0, 1, 32'h14, 1, 1, I_BEQ8, 0, 32'h18), 134);
        apply(mk(1, I_JALM4, 3'b000, 0, 0, 1, 32'h10, 1, 1, I_JALM4, 0, 32'h18), 135);
        apply(mk(1, I_BEQ8, 3'b000, 0, 0, 1, 32'h14, 1, 1, I_BEQ8, 0, 32'h18), 136);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
